prog_mem_loader: RTL and testbench

//  Program memory for the SoC, serving the processor's fetch port.
//  It also runs an on-chip byte-stream loader that fills the memory at boot.

---
 rtl/prog_mem_pkg.sv | 19 +
 rtl/prog_mem_ram.sv | 44 ++++
 rtl/prog_mem_loader.sv | 151 +++++++++++++++
 tb/tb_prog_mem_loader.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/prog_mem_pkg.sv
// Shared types for the program memory loader: FSM state encoding and length-byte decode.
package prog_mem_pkg;

  typedef enum logic [2:0] {
    LOAD_LEN  = 3'd0,
    LOAD_DATA = 3'd1,
    LOAD_CSUM = 3'd2,
    RUN       = 3'd3,
    ERROR     = 3'd4
  } state_e;

  localparam int unsigned LEN_W = 9;

  // A length byte of zero encodes a full 256-byte image.
  function automatic logic [LEN_W-1:0] len_decode(input logic [7:0] len_byte);
    return (len_byte == 8'd0) ? 9'd256 : {1'b0, len_byte};
  endfunction

endpackage

// File: rtl/prog_mem_ram.sv
// Program RAM: one synchronous write port, one synchronous read port with enable.
// The read register clears on reset; array contents are never cleared.
module prog_mem_ram #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/prog_mem_loader.sv
// Boot-time program memory: byte-stream loader (length, data, checksum) fills the RAM
// while the CPU is held; after a verified load the CPU fetches from the RAM.
module prog_mem_loader
  import prog_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter bit          CSUM_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] memAddr,
  input  logic                  memStrobe,
  output logic [7:0]            memDataRead,
  input  logic [7:0]            loadData,
  input  logic                  loadValid,
  output logic                  loadReady,
  input  logic                  loadRestart,
  output logic                  cpuHold,
  output logic                  loadDone,
  output logic                  loadError
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]              sum_q, sum_d;
  logic                    cpu_hold_q, cpu_hold_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    load_ready;
  logic                    accept;
  logic [7:0]              csum_total;
  logic                    ram_we;
  logic                    ram_re;

  always_comb begin
    load_ready = (state_q == LOAD_LEN) || (state_q == LOAD_DATA) || (state_q == LOAD_CSUM);
  end

  // Restart suppresses acceptance so a byte arriving alongside it is dropped entirely.
  assign accept     = loadValid && load_ready && !loadRestart;
  assign csum_total = sum_q + loadData;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_addr_d = wr_addr_q;
    sum_d     = sum_q;
    done_d    = 1'b0;
    err_d     = err_q;

    if (loadRestart) begin
      state_d = LOAD_LEN;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        LOAD_LEN: begin
          if (accept) begin
            len_d     = len_decode(loadData);
            wr_addr_d = '0;
            sum_d     = '0;
            state_d   = LOAD_DATA;
          end
        end
        LOAD_DATA: begin
          if (accept) begin
            sum_d     = sum_q + loadData;
            wr_addr_d = wr_addr_q + ADDR_ONE;
            len_d     = len_q - 9'd1;
            if (len_q == 9'd1) begin
              if (CSUM_EN) begin
                state_d = LOAD_CSUM;
              end else begin
                state_d = RUN;
                done_d  = 1'b1;
              end
            end
          end
        end
        LOAD_CSUM: begin
          if (accept) begin
            if (csum_total == 8'd0) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              state_d = ERROR;
              err_d   = 1'b1;
            end
          end
        end
        RUN: begin
          state_d = RUN;
        end
        ERROR: begin
          state_d = ERROR;
        end
        default: begin
          state_d = LOAD_LEN;
        end
      endcase
    end

    cpu_hold_d = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOAD_LEN;
      len_q      <= '0;
      wr_addr_q  <= '0;
      sum_q      <= '0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_addr_q  <= wr_addr_d;
      sum_q      <= sum_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ram_we = accept && (state_q == LOAD_DATA);
  assign ram_re = memStrobe && (state_q == RUN);

  prog_mem_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (8)
  ) u_ram (
    .clk   (clk),
    .rst   (reset),
    .we    (ram_we),
    .waddr (wr_addr_q),
    .wdata (loadData),
    .re    (ram_re),
    .raddr (memAddr),
    .rdata (memDataRead)
  );

  assign loadReady = load_ready;
  assign cpuHold   = cpu_hold_q;
  assign loadDone  = done_q;
  assign loadError = err_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: load, read-back, checksum error, wrap, restart and reset cases.
module tb_prog_mem_loader;

  logic       clk;
  logic       reset;
  logic [7:0] memAddr;
  logic       memStrobe;
  logic [7:0] memDataRead;
  logic [7:0] loadData;
  logic       loadValid;
  logic       loadReady;
  logic       loadRestart;
  logic       cpuHold;
  logic       loadDone;
  logic       loadError;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  prog_mem_loader #(
    .ADDR_WIDTH (8),
    .CSUM_EN    (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memAddr     (memAddr),
    .memStrobe   (memStrobe),
    .memDataRead (memDataRead),
    .loadData    (loadData),
    .loadValid   (loadValid),
    .loadReady   (loadReady),
    .loadRestart (loadRestart),
    .cpuHold     (cpuHold),
    .loadDone    (loadDone),
    .loadError   (loadError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    loadData  = b;
    loadValid = 1'b1;
    step();
    loadValid = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    memAddr   = a;
    memStrobe = 1'b1;
    step();
    memStrobe = 1'b0;
    chk(tag, {24'd0, memDataRead}, {24'd0, exp});
  endtask

  task automatic restart_pulse();
    loadRestart = 1'b1;
    step();
    loadRestart = 1'b0;
  endtask

  initial begin
    logic seen_done;
    logic [7:0] b;

    reset       = 1'b1;
    memAddr     = '0;
    memStrobe   = 1'b0;
    loadData    = '0;
    loadValid   = 1'b0;
    loadRestart = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Idle after reset
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen_done = seen_done | loadDone;
    end
    chk("rst_cpuHold",   {31'd0, cpuHold},   32'd1);
    chk("rst_loadReady", {31'd0, loadReady}, 32'd1);
    chk("rst_memData",   {24'd0, memDataRead}, 32'd0);
    chk("rst_noDone",    {31'd0, seen_done}, 32'd0);
    chk("rst_loadError", {31'd0, loadError}, 32'd0);

    // 3-byte image AA,BB,CC; checksum CF makes the total 0 mod 256
    send(8'h03);
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    chk("img3_hold_before_csum", {31'd0, cpuHold}, 32'd1);
    send(8'hCF);
    chk("img3_done",     {31'd0, loadDone},  32'd1);
    chk("img3_cpuHold",  {31'd0, cpuHold},   32'd0);
    chk("img3_ready",    {31'd0, loadReady}, 32'd0);
    step();
    chk("img3_done_pulse", {31'd0, loadDone}, 32'd0);
    read_chk("img3_rd01", 8'h01, 8'hBB);
    read_chk("img3_rd00", 8'h00, 8'hAA);
    read_chk("img3_rd02", 8'h02, 8'hCC);
    memAddr = 8'h00;
    step();
    chk("img3_hold_nostrobe", {24'd0, memDataRead}, 32'h0000_00CC);

    // Bad checksum: 10+20+00 != 0
    restart_pulse();
    chk("rs_run_cpuHold", {31'd0, cpuHold}, 32'd1);
    send(8'h02);
    send(8'h10);
    send(8'h20);
    send(8'h00);
    chk("bad_loadError", {31'd0, loadError}, 32'd1);
    chk("bad_cpuHold",   {31'd0, cpuHold},   32'd1);
    chk("bad_ready",     {31'd0, loadReady}, 32'd0);
    chk("bad_noDone",    {31'd0, loadDone},  32'd0);
    read_chk("bad_strobe_ignored", 8'h01, 8'hCC);
    step();
    chk("bad_sticky", {31'd0, loadError}, 32'd1);
    restart_pulse();
    chk("bad_rs_error", {31'd0, loadError}, 32'd0);
    chk("bad_rs_ready", {31'd0, loadReady}, 32'd1);
    chk("bad_rs_hold",  {31'd0, cpuHold},   32'd1);

    // 256-byte image, value = index; sum = 0x80, checksum 0x80
    send(8'h00);
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      send(b);
    end
    chk("wrap_in_csum_ready", {31'd0, loadReady}, 32'd1);
    send(8'h80);
    chk("wrap_done",    {31'd0, loadDone}, 32'd1);
    chk("wrap_cpuHold", {31'd0, cpuHold},  32'd0);
    read_chk("wrap_rdFF", 8'hFF, 8'hFF);
    read_chk("wrap_rd00", 8'h00, 8'h00);
    read_chk("wrap_rd80", 8'h80, 8'h80);

    // Restart with a byte alongside: that byte must be neither written nor taken as length
    restart_pulse();
    send(8'h03);
    send(8'h55);
    loadData    = 8'h77;
    loadValid   = 1'b1;
    loadRestart = 1'b1;
    step();
    loadValid   = 1'b0;
    loadRestart = 1'b0;
    chk("mid_rs_ready", {31'd0, loadReady}, 32'd1);
    send(8'h01);
    send(8'h11);
    send(8'hEF);
    chk("mid_done",    {31'd0, loadDone}, 32'd1);
    chk("mid_cpuHold", {31'd0, cpuHold},  32'd0);
    read_chk("mid_rd00", 8'h00, 8'h11);
    read_chk("mid_rd01", 8'h01, 8'h01);
    read_chk("mid_rd02", 8'h02, 8'h02);

    // Reset while running; RAM must survive
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rr_cpuHold",   {31'd0, cpuHold},   32'd1);
    chk("rr_ready",     {31'd0, loadReady}, 32'd1);
    chk("rr_memData",   {24'd0, memDataRead}, 32'd0);
    send(8'h01);
    send(8'h5A);
    send(8'hA6);
    chk("rr_done", {31'd0, loadDone}, 32'd1);
    read_chk("rr_rd00", 8'h00, 8'h5A);
    read_chk("rr_rd01", 8'h01, 8'h01);
    read_chk("rr_rdFF", 8'hFF, 8'hFF);
    read_chk("rr_rdFE", 8'hFE, 8'hFE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
